// File: rtl/tx_ffe_driver_pkg.sv
// Shared types and helpers for the TX FFE driver: default-width formats,
// commit FSM states, PRBS7 constants and the output saturation helper.
package tx_ffe_package;

   localparam int unsigned N_TAPS_DEF    = 4;
   localparam int unsigned TAP_WIDTH_DEF = 10;
   localparam int unsigned OUT_WIDTH_DEF = 12;
   localparam int unsigned ACC_WIDTH_DEF = TAP_WIDTH_DEF + $clog2(N_TAPS_DEF) + 1;

   typedef logic signed [TAP_WIDTH_DEF-1:0] tap_format_t;
   typedef logic signed [ACC_WIDTH_DEF-1:0] acc_format_t;
   typedef logic signed [OUT_WIDTH_DEF-1:0] out_format_t;

   typedef enum logic {
      ST_IDLE,
      ST_COMMIT
   } commit_state_t;

   // PRBS7, x^7 + x^6 + 1: feedback taps are register bits 6 and 5.
   localparam logic [6:0] PRBS7_SEED = 7'h7F;
   localparam logic [6:0] PRBS7_MASK = 7'h60;

   // Accumulator width that cannot overflow when summing n_taps coefficients.
   function automatic int unsigned acc_width(input int unsigned n_taps,
                                             input int unsigned tap_width);
      return tap_width + $clog2(n_taps) + 1;
   endfunction

   // Clamp a signed value into the signed range of a w-bit word.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/tx_ffe_driver_if.sv
// Coefficient configuration port of the TX FFE driver: valid/ready tap
// writes into the shadow bank plus the commit pulse and its completion flag.
interface tx_ffe_driver_if
   import tx_ffe_package::*;
#(
   parameter int N_TAPS        = 4,
   parameter int TAP_WIDTH     = 10,
   parameter int TAP_IDX_WIDTH = $clog2(N_TAPS)
);

   logic                     cfg_valid;
   logic                     cfg_ready;
   logic [TAP_IDX_WIDTH-1:0] cfg_tap;
   logic                     cfg_pol;
   logic [TAP_WIDTH-1:0]     cfg_data;
   logic                     cfg_commit;
   logic                     commit_done;

   modport master (
      output cfg_valid, cfg_tap, cfg_pol, cfg_data, cfg_commit,
      input  cfg_ready, commit_done
   );

   modport slave (
      input  cfg_valid, cfg_tap, cfg_pol, cfg_data, cfg_commit,
      output cfg_ready, commit_done
   );

endinterface

// File: rtl/tx_ffe_driver_coef_bank.sv
// Shadow/active coefficient banks for the TX FFE driver. Writes land in the
// shadow bank; a commit copies the whole shadow bank (both polarities) into
// the active bank in a single edge.
module tx_ffe_coef_bank
   import tx_ffe_package::*;
#(
   parameter int N_TAPS        = 4,
   parameter int TAP_WIDTH     = 10,
   parameter int TAP_IDX_WIDTH = $clog2(N_TAPS)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   tx_ffe_driver_if.slave                    cfg,
   output logic [N_TAPS-1:0][TAP_WIDTH-1:0]  act_plus,
   output logic [N_TAPS-1:0][TAP_WIDTH-1:0]  act_minus
);

   logic [N_TAPS-1:0][TAP_WIDTH-1:0] shadow_plus;
   logic [N_TAPS-1:0][TAP_WIDTH-1:0] shadow_minus;
   commit_state_t                    state;
   logic                             wr_fire;
   logic                             wr_in_range;

   assign wr_fire     = cfg.cfg_valid && cfg.cfg_ready;
   assign wr_in_range = int'(cfg.cfg_tap) < N_TAPS;

   // Shadow bank write decode; out-of-range tap indices are accepted and dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_plus  <= '0;
         shadow_minus <= '0;
      end else if (wr_fire && wr_in_range) begin
         if (cfg.cfg_pol) begin
            shadow_plus[cfg.cfg_tap] <= cfg.cfg_data;
         end else begin
            shadow_minus[cfg.cfg_tap] <= cfg.cfg_data;
         end
      end
   end

   // Commit FSM: the copy happens on the edge leaving COMMIT, so a write
   // accepted alongside the commit request is already in the shadow bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         cfg.cfg_ready   <= 1'b1;
         cfg.commit_done <= 1'b0;
         act_plus        <= '0;
         act_minus       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg.cfg_commit) begin
                  state           <= ST_COMMIT;
                  cfg.cfg_ready   <= 1'b0;
                  cfg.commit_done <= 1'b1;
               end
            end
            ST_COMMIT: begin
               act_plus        <= shadow_plus;
               act_minus       <= shadow_minus;
               state           <= ST_IDLE;
               cfg.cfg_ready   <= 1'b1;
               cfg.commit_done <= 1'b0;
            end
            default: begin
               state           <= ST_IDLE;
               cfg.cfg_ready   <= 1'b1;
               cfg.commit_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tx_ffe_driver.sv
// PAM2 transmit FFE driver: transposed-form FIR over runtime-loadable tap
// weights, with drain-to-zero enable and saturated registered output.
// Optional build macro TX_FFE_PRBS_EN adds a prbs_mode input and an internal
// PRBS7 source that can replace the symbol input.
module tx_ffe_driver
   import tx_ffe_package::*;
#(
   parameter int N_TAPS        = 4,
   parameter int TAP_WIDTH     = 10,
   parameter int OUT_WIDTH     = 12,
   parameter int TAP_IDX_WIDTH = $clog2(N_TAPS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in,
   input  logic                        en,
`ifdef TX_FFE_PRBS_EN
   input  logic                        prbs_mode,
`endif
   tx_ffe_driver_if.slave              cfg,
   output logic signed [OUT_WIDTH-1:0] out
);

   localparam int unsigned ACC_W = acc_width(N_TAPS, TAP_WIDTH);

   logic [N_TAPS-1:0][TAP_WIDTH-1:0] act_plus;
   logic [N_TAPS-1:0][TAP_WIDTH-1:0] act_minus;
   logic signed [ACC_W-1:0]          weight [N_TAPS];
   logic signed [ACC_W-1:0]          st     [N_TAPS];
   logic signed [ACC_W-1:0]          st0_nxt;
   logic                             sym;

`ifdef TX_FFE_PRBS_EN
   logic [6:0] lfsr;

   // Free-running PRBS7 generator, advancing every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= PRBS7_SEED;
      end else begin
         lfsr <= {lfsr[5:0], ^(lfsr & PRBS7_MASK)};
      end
   end

   assign sym = prbs_mode ? lfsr[6] : in;
`else
   assign sym = in;
`endif

   tx_ffe_coef_bank #(
      .N_TAPS        (N_TAPS),
      .TAP_WIDTH     (TAP_WIDTH),
      .TAP_IDX_WIDTH (TAP_IDX_WIDTH)
   ) u_coef_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg       (cfg),
      .act_plus  (act_plus),
      .act_minus (act_minus)
   );

   // Per-tap weight selection from the active bank, zero while draining.
   always_comb begin
      for (int unsigned k = 0; k < N_TAPS; k++) begin
         weight[k] = '0;
         if (en) begin
            weight[k] = sym ? ACC_W'(signed'(act_plus[k]))
                            : ACC_W'(signed'(act_minus[k]));
         end
      end
      st0_nxt = weight[0] + st[1];
   end

   // Transposed FIR chain: each stage adds its weight to the later stage's partial sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < N_TAPS; k++) begin
            st[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < N_TAPS - 1; k++) begin
            st[k] <= weight[k] + st[k+1];
         end
         st[N_TAPS-1] <= weight[N_TAPS-1];
      end
   end

   // Output register saturates the next stage-0 sum, so out tracks stage 0
   // with no extra latency and no combinational path from the symbol input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else begin
         out <= OUT_WIDTH'(saturate(64'(st0_nxt), OUT_WIDTH));
      end
   end

endmodule

// File: tb/tb_tx_ffe_driver.sv
// Scoreboard bench for tx_ffe_driver (N_TAPS=3, TAP_WIDTH=8, OUT_WIDTH=8).
module tb_tx_ffe_driver;

   localparam int NT = 3;
   localparam int TW = 8;
   localparam int OW = 8;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 sym   = 1'b0;
   logic                 en    = 1'b0;
   logic signed [OW-1:0] dout;
`ifdef TX_FFE_PRBS_EN
   logic                 prbs_mode = 1'b0;
`endif

   tx_ffe_driver_if #(.N_TAPS(NT), .TAP_WIDTH(TW)) cfg_if ();

   tx_ffe_driver #(
      .N_TAPS    (NT),
      .TAP_WIDTH (TW),
      .OUT_WIDTH (OW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (sym),
      .en        (en),
`ifdef TX_FFE_PRBS_EN
      .prbs_mode (prbs_mode),
`endif
      .cfg       (cfg_if),
      .out       (dout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int o;
      bit rdy;
      bit done;
   } exp_t;

   exp_t sb[$];

   // Reference model: banks as integer arrays, per-symbol weight history.
   int sh_p[NT], sh_m[NT], act_p[NT], act_m[NT];
   int hist[NT][NT];
   bit m_commit;
   bit last_acc;

   function automatic int sat(input int v);
      int hi, lo;
      hi = (1 << (OW - 1)) - 1;
      lo = -(1 << (OW - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NT; k++) begin
         sh_p[k] = 0; sh_m[k] = 0; act_p[k] = 0; act_m[k] = 0;
         for (int d = 0; d < NT; d++) hist[d][k] = 0;
      end
      m_commit = 0;
      last_acc = 0;
      sb.delete();
   endfunction

   // One clock edge of the model: output is the sum over taps k of the
   // tap-k weight of the symbol sent k edges ago.
   function automatic void model_edge(input bit i, input bit e, input bit v,
                                      input int tap, input bit pol,
                                      input int data, input bit cm);
      int   sum;
      exp_t x;
      for (int d = NT - 1; d > 0; d--)
         for (int k = 0; k < NT; k++) hist[d][k] = hist[d-1][k];
      for (int k = 0; k < NT; k++) hist[0][k] = e ? (i ? act_p[k] : act_m[k]) : 0;
      sum = 0;
      for (int k = 0; k < NT; k++) sum += hist[k][k];
      last_acc = 0;
      if (m_commit) begin
         act_p = sh_p;
         act_m = sh_m;
         m_commit = 0;
      end else begin
         if (v) begin
            last_acc = 1;
            if (tap < NT) begin
               if (pol) sh_p[tap] = data;
               else     sh_m[tap] = data;
            end
         end
         if (cm) m_commit = 1;
      end
      x.o    = sat(sum);
      x.rdy  = !m_commit;
      x.done = m_commit;
      sb.push_back(x);
   endfunction

   task automatic step(input bit i, input bit e, input bit v = 0, input int tap = 0,
                       input bit pol = 0, input int data = 0, input bit cm = 0);
      @(negedge clk);
      sym               = i;
      en                = e;
      cfg_if.cfg_valid  = v;
      cfg_if.cfg_tap    = 2'(tap);
      cfg_if.cfg_pol    = pol;
      cfg_if.cfg_data   = data[TW-1:0];
      cfg_if.cfg_commit = cm;
      @(posedge clk);
      model_edge(i, e, v, tap, pol, data, cm);
   endtask

   // Hold a write until the model says it was accepted.
   task automatic write(input int tap, input bit pol, input int data, input bit cm = 0);
      int n;
      n = 0;
      do begin
         step(1'b1, 1'b1, 1'b1, tap, pol, data, cm);
         n++;
      end while (!last_acc && n < 8);
      if (!last_acc) begin
         checks++;
         errors++;
         $display("FAIL write_accept_timeout tap=%0d: not accepted within %0d cycles", tap, n);
      end
   endtask

   task automatic load(input int p[NT], input int m[NT]);
      for (int k = 0; k < NT; k++) begin
         write(k, 1'b1, p[k]);
         write(k, 1'b0, m[k]);
      end
      step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
   endtask

   task automatic expect_out(input string nm, input int val);
      #1;
      checks++;
      if (dout !== OW'(val)) begin
         errors++;
         $display("FAIL %s: out=%0d expected=%0d", nm, dout, val);
      end
   endtask

   task automatic check_idle_outputs(input string nm);
      checks++;
      if (dout !== '0 || cfg_if.cfg_ready !== 1'b1 || cfg_if.commit_done !== 1'b0) begin
         errors++;
         $display("FAIL %s: out=%0d ready=%b done=%b expected out=0 ready=1 done=0",
                  nm, dout, cfg_if.cfg_ready, cfg_if.commit_done);
      end
   endtask

   // Monitor: the output is valid every cycle out of reset.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (dout !== OW'(x.o)) begin
               errors++;
               $display("FAIL sb_out @%0t: out=%0d expected=%0d", $time, dout, x.o);
            end
            checks++;
            if (cfg_if.cfg_ready !== x.rdy) begin
               errors++;
               $display("FAIL sb_ready @%0t: cfg_ready=%b expected=%b", $time, cfg_if.cfg_ready, x.rdy);
            end
            checks++;
            if (cfg_if.commit_done !== x.done) begin
               errors++;
               $display("FAIL sb_commit_done @%0t: commit_done=%b expected=%b", $time, cfg_if.commit_done, x.done);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_if.cfg_valid  = 1'b0;
      cfg_if.cfg_tap    = '0;
      cfg_if.cfg_pol    = 1'b0;
      cfg_if.cfg_data   = '0;
      cfg_if.cfg_commit = 1'b0;
      model_reset();

      // Reset held with the symbol toggling.
      repeat (4) begin
         @(negedge clk);
         sym = ~sym;
         @(posedge clk);
         #1;
         check_idle_outputs("reset_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Basic tap response.
      load('{64, -16, 8}, '{-64, 16, -8});
      repeat (4) step(1'b1, 1'b1);
      expect_out("steady_plus", 56);
      step(1'b0, 1'b1);
      expect_out("single_minus", -72);
      step(1'b1, 1'b1);
      expect_out("back_to_plus", 88);

      // Saturation at both rails.
      load('{100, 100, 100}, '{-100, -100, -100});
      repeat (4) step(1'b1, 1'b1);
      expect_out("sat_high", 127);
      repeat (3) step(1'b0, 1'b1);
      expect_out("sat_low", -128);

      // Drain with en low.
      load('{64, -16, 8}, '{-64, 16, -8});
      repeat (4) step(1'b1, 1'b1);
      expect_out("drain_start", 56);
      step(1'b1, 1'b0);
      expect_out("drain_1", -8);
      step(1'b1, 1'b0);
      expect_out("drain_2", 8);
      step(1'b1, 1'b0);
      expect_out("drain_3", 0);
      repeat (2) step(1'b1, 1'b0);
      expect_out("drain_hold", 0);

      // Shadow write without commit leaves output unchanged.
      write(0, 1'b1, 10);
      repeat (4) step(1'b1, 1'b1);
      expect_out("shadow_no_commit", 56);

      // Write and commit in the same cycle.
      write(0, 1'b1, 32, 1'b1);
      repeat (4) step(1'b1, 1'b1);
      expect_out("write_with_commit", 24);

      // Write presented during COMMIT stalls one cycle.
      step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
      write(0, 1'b1, 64);
      step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
      repeat (4) step(1'b1, 1'b1);
      expect_out("write_after_stall", 56);

      // Out-of-range tap index is discarded.
      write(3, 1'b1, 99);
      step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
      repeat (4) step(1'b1, 1'b1);
      expect_out("tap_out_of_range", 56);

      // Random traffic against the model.
      repeat (300) begin
         step(1'($urandom), ($urandom % 8) != 0, ($urandom % 4) == 0,
              int'($urandom % 4), 1'($urandom),
              int'($urandom_range(255, 0)) - 128, ($urandom % 12) == 0);
      end

      // Asynchronous reset in the middle of a cycle clears everything.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) step(1'b1, 1'b1);
      expect_out("banks_cleared_plus", 0);
      repeat (3) step(1'b0, 1'b1);
      expect_out("banks_cleared_minus", 0);

      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
